// File: rtl/ov7670_capture.sv
// OV7670 capture front end: xclk and power sequencing, pclk-domain sampling in clk_50,
// Y extraction from YCbCr 4:2:2, optional 2x downscale and border, frame buffer write strobes.
module ov7670_capture #(
  parameter int unsigned H_ACTIVE   = 320,
  parameter int unsigned V_ACTIVE   = 240,
  parameter int unsigned DECIM      = 1,
  parameter int unsigned Y_BYTE     = 1,
  parameter int unsigned XCLK_DIV   = 4,
  parameter int unsigned RST_HOLD   = 1024,
  parameter int unsigned BORDER     = 1,
  parameter logic [7:0]  BORDER_VAL = 8'hFF,
  parameter int unsigned XW         = 10,
  parameter int unsigned YW         = 10,
  parameter int unsigned MEM_AW     = 19
) (
  input  logic              clk_50,
  input  logic              reset,
  output logic              xclk,
  input  logic              pclk,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  output logic              cam_rst_n,
  output logic              cam_pwdn,
  output logic [7:0]        value,
  output logic [XW-1:0]     x_addr,
  output logic [YW-1:0]     y_addr,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              is_val,
  output logic              frame_start,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              line_err
);

  localparam int unsigned OUT_W = H_ACTIVE / DECIM;
  localparam int unsigned OUT_H = V_ACTIVE / DECIM;
  localparam int unsigned HALF  = XCLK_DIV / 2;
  localparam int unsigned DW    = $clog2(HALF + 1);
  localparam int unsigned HW    = $clog2(RST_HOLD + 1);
  localparam logic [XW-1:0] OUT_W_X = XW'(OUT_W);
  localparam logic [YW-1:0] OUT_H_Y = YW'(OUT_H);

  typedef enum logic [1:0] {S_SYNC, S_VSYNC, S_WAIT, S_LINE} state_t;

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] hold_cnt;

  // Camera master clock
  always_ff @(posedge clk_50) begin
    if (reset) begin
      xclk    <= 1'b0;
      div_cnt <= '0;
    end else if (div_cnt == DW'(HALF - 1)) begin
      div_cnt <= '0;
      xclk    <= ~xclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Power-down release, then hold the camera in reset for RST_HOLD cycles
  always_ff @(posedge clk_50) begin
    if (reset) begin
      cam_pwdn  <= 1'b1;
      cam_rst_n <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      cam_pwdn <= 1'b0;
      if (!cam_pwdn && !cam_rst_n) begin
        if (hold_cnt == HW'(RST_HOLD - 1)) cam_rst_n <= 1'b1;
        else hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

  logic p1, p2, p3, h1, h2, v1, v2;
  logic [7:0] d1, d2;

  // Two-flop synchronisers; p3 provides the pclk rise event
  always_ff @(posedge clk_50) begin
    if (reset) begin
      {p1, p2, p3, h1, h2, v1, v2} <= '0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      p1 <= pclk;  p2 <= p1;  p3 <= p2;
      h1 <= href;  h2 <= h1;
      v1 <= vsync; v2 <= v1;
      d1 <= data;  d2 <= d1;
    end
  end

  state_t            state;
  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [MEM_AW-1:0] mem_cnt, row_base;
  logic              phase, pair, line_par, first_line, any_emit;
  logic [7:0]        acc;

  logic       rise, emit_line, cur_phase, take, is_y, do_emit, ovf, on_border;
  logic [7:0] pix;

  assign rise      = p2 & ~p3 & cam_rst_n;
  assign emit_line = (DECIM == 1) || !line_par;
  assign cur_phase = (state == S_LINE) ? phase : 1'b0;
  assign take      = rise && h2 && !v2 && (state == S_WAIT || state == S_LINE);
  assign is_y      = take && (cur_phase == 1'(Y_BYTE));
  assign do_emit   = is_y && emit_line && ((DECIM == 1) || pair);
  assign pix       = (DECIM == 1) ? d2 : 8'(({1'b0, acc} + {1'b0, d2}) >> 1);
  assign ovf       = (x_cnt >= OUT_W_X) || (y_cnt >= OUT_H_Y);
  assign on_border = (BORDER == 1) && (x_cnt == '0 || x_cnt == OUT_W_X - XW'(1) ||
                                       y_cnt == '0 || y_cnt == OUT_H_Y - YW'(1));

  // Frame/line tracking and pixel emission, advanced only on pclk rise events
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state <= S_SYNC;
      {x_cnt, y_cnt, mem_cnt, row_base} <= '0;
      {phase, pair, line_par, first_line, any_emit} <= '0;
      acc <= '0;
      value <= '0; x_addr <= '0; y_addr <= '0; mem_addr <= '0;
      is_val <= 1'b0; frame_start <= 1'b0; frame_done <= 1'b0;
      frame_cnt <= '0; line_err <= 1'b0;
    end else begin
      is_val      <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (rise) begin
        case (state)
          S_SYNC: if (v2) state <= S_VSYNC;
          S_VSYNC: begin
            {x_cnt, y_cnt, mem_cnt, row_base} <= '0;
            {phase, pair, line_par, any_emit} <= '0;
            acc        <= '0;
            first_line <= 1'b1;
            if (!v2) state <= S_WAIT;
          end
          S_WAIT: begin
            if (v2) begin
              state <= S_VSYNC;
              if (any_emit) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
              end
            end else if (h2) begin
              state       <= S_LINE;
              phase       <= 1'b1;
              frame_start <= first_line;
              first_line  <= 1'b0;
            end
          end
          S_LINE: begin
            if (v2) begin
              state    <= S_VSYNC;
              line_err <= 1'b1;
              if (any_emit) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
              end
            end else if (!h2) begin
              state    <= S_WAIT;
              x_cnt    <= '0;
              pair     <= 1'b0;
              line_par <= ~line_par;
              if (emit_line && x_cnt != OUT_W_X) line_err <= 1'b1;
              // Row base keeps mem_addr aligned even after a short or long line
              if (emit_line) begin
                if (y_cnt < OUT_H_Y) y_cnt <= y_cnt + YW'(1);
                row_base <= row_base + MEM_AW'(OUT_W);
                mem_cnt  <= row_base + MEM_AW'(OUT_W);
              end else begin
                mem_cnt <= row_base;
              end
            end else begin
              phase <= ~phase;
            end
          end
          default: state <= S_SYNC;
        endcase
      end

      if (is_y && emit_line && (DECIM != 1) && !pair) begin
        acc  <= d2;
        pair <= 1'b1;
      end

      if (do_emit) begin
        pair <= 1'b0;
        if (ovf) begin
          line_err <= 1'b1;
        end else begin
          is_val   <= 1'b1;
          value    <= on_border ? BORDER_VAL : pix;
          x_addr   <= x_cnt;
          y_addr   <= y_cnt;
          mem_addr <= mem_cnt;
          x_cnt    <= x_cnt + XW'(1);
          mem_cnt  <= mem_cnt + MEM_AW'(1);
          any_emit <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a reduced 8x4 geometry: three instances
// (DECIM=1 plain, DECIM=2, DECIM=1 with border) share one camera stream.
module tb_ov7670_capture;

  localparam int unsigned RST_HOLD = 1024;

  logic clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  logic reset, pclk, vsync, href;
  logic [7:0] data;

  logic a_xclk, a_rst_n, a_pwdn, a_val, a_fs, a_fd, a_err;
  logic b_xclk, b_rst_n, b_pwdn, b_val, b_fs, b_fd, b_err;
  logic c_xclk, c_rst_n, c_pwdn, c_val, c_fs, c_fd, c_err;
  logic [7:0]  a_value, b_value, c_value;
  logic [9:0]  a_x, a_y, b_x, b_y, c_x, c_y;
  logic [18:0] a_mem, b_mem, c_mem;
  logic [15:0] a_fcnt, b_fcnt, c_fcnt;

  ov7670_capture #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(1), .BORDER(0), .RST_HOLD(RST_HOLD)) u_a (
    .clk_50(clk_50), .reset(reset), .xclk(a_xclk), .pclk(pclk), .vsync(vsync), .href(href),
    .data(data), .cam_rst_n(a_rst_n), .cam_pwdn(a_pwdn), .value(a_value), .x_addr(a_x),
    .y_addr(a_y), .mem_addr(a_mem), .is_val(a_val), .frame_start(a_fs), .frame_done(a_fd),
    .frame_cnt(a_fcnt), .line_err(a_err));

  ov7670_capture #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(2), .BORDER(0), .RST_HOLD(RST_HOLD)) u_b (
    .clk_50(clk_50), .reset(reset), .xclk(b_xclk), .pclk(pclk), .vsync(vsync), .href(href),
    .data(data), .cam_rst_n(b_rst_n), .cam_pwdn(b_pwdn), .value(b_value), .x_addr(b_x),
    .y_addr(b_y), .mem_addr(b_mem), .is_val(b_val), .frame_start(b_fs), .frame_done(b_fd),
    .frame_cnt(b_fcnt), .line_err(b_err));

  ov7670_capture #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(1), .BORDER(1), .RST_HOLD(RST_HOLD)) u_c (
    .clk_50(clk_50), .reset(reset), .xclk(c_xclk), .pclk(pclk), .vsync(vsync), .href(href),
    .data(data), .cam_rst_n(c_rst_n), .cam_pwdn(c_pwdn), .value(c_value), .x_addr(c_x),
    .y_addr(c_y), .mem_addr(c_mem), .is_val(c_val), .frame_start(c_fs), .frame_done(c_fd),
    .frame_cnt(c_fcnt), .line_err(c_err));

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [18:0] m;
    logic [7:0]  v;
  } pix_t;

  pix_t qa[$], qb[$], qc[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_rise = 0, lat_a = -1;
  int fd_a = 0, fd_b = 0, fd_c = 0, fs_a = 0, fs_b = 0, fs_c = 0;

  always @(posedge clk_50) cyc <= cyc + 1;

  // Record every write strobe and frame pulse
  always @(negedge clk_50) begin
    if (a_val) begin
      qa.push_back({a_x, a_y, a_mem, a_value});
      if (lat_a < 0) lat_a = cyc - last_rise;
    end
    if (b_val) qb.push_back({b_x, b_y, b_mem, b_value});
    if (c_val) qc.push_back({c_x, c_y, c_mem, c_value});
    if (a_fd) fd_a++;
    if (b_fd) fd_b++;
    if (c_fd) fd_c++;
    if (a_fs) fs_a++;
    if (b_fs) fs_b++;
    if (c_fs) fs_c++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] base(input int c);
    case (c)
      0: return 8'd10;  1: return 8'd13;  2: return 8'd200; 3: return 8'd201;
      4: return 8'd50;  5: return 8'd60;  6: return 8'd7;   7: return 8'd8;
      default: return 8'd99;
    endcase
  endfunction

  function automatic logic [7:0] yv(input int r, input int c);
    return (r % 2 == 1) ? 8'hFF : 8'(base(c) + 8'(r));
  endfunction

  function automatic pix_t exp_a(input int k, input logic brd);
    pix_t p;
    int x = k % 8, y = k / 8;
    p.x = 10'(x); p.y = 10'(y); p.m = 19'(k);
    p.v = (brd && (x == 0 || x == 7 || y == 0 || y == 3)) ? 8'hFF : yv(y, x);
    return p;
  endfunction

  function automatic pix_t exp_b(input int k);
    pix_t p;
    int x = k % 4, y = k / 4;
    p.x = 10'(x); p.y = 10'(y); p.m = 19'(k);
    p.v = 8'((9'(yv(2 * y, 2 * x)) + 9'(yv(2 * y, 2 * x + 1))) >> 1);
    return p;
  endfunction

  task automatic cam_byte(input logic [7:0] b, input logic h);
    @(negedge clk_50); data = b; href = h; pclk = 1'b0;
    @(negedge clk_50);
    @(negedge clk_50); pclk = 1'b1; last_rise = cyc;
    @(negedge clk_50);
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    repeat (3) cam_byte(8'h00, 1'b0);
    vsync = 1'b0;
    repeat (2) cam_byte(8'h00, 1'b0);
  endtask

  task automatic send_line(input int r, input int nsamp, input int abort_at);
    for (int c = 0; c < nsamp; c++) begin
      if (c == abort_at) begin
        vsync = 1'b1;
        cam_byte(8'h80, 1'b1);
        cam_byte(8'h80, 1'b0);
        cam_byte(8'h80, 1'b0);
        vsync = 1'b0;
        repeat (2) cam_byte(8'h00, 1'b0);
        return;
      end
      cam_byte(8'h80, 1'b1);
      cam_byte(yv(r, c), 1'b1);
    end
    repeat (2) cam_byte(8'h80, 1'b0);
  endtask

  initial begin
    int t0, t1;
    logic prev;
    reset = 1'b1; pclk = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;

    // Reset state and power sequencing
    repeat (5) @(negedge clk_50);
    check("rst_xclk", 64'({a_xclk, b_xclk, c_xclk}), 64'd0);
    check("rst_pwr_a", 64'({a_pwdn, a_rst_n}), 64'b10);
    check("rst_outs_a", 64'({a_val, a_fs, a_fd, a_err, a_fcnt, a_value, a_x, a_y, a_mem}), 64'd0);
    reset = 1'b0;
    @(negedge clk_50);
    check("pwdn_drop", 64'({a_pwdn, a_rst_n, b_pwdn, c_pwdn}), 64'b0000);
    repeat (RST_HOLD - 1) @(negedge clk_50);
    check("rst_n_hold", 64'(a_rst_n), 64'd0);
    @(negedge clk_50);
    check("rst_n_rise", 64'({a_rst_n, b_rst_n, c_rst_n}), 64'b111);

    t0 = -1; t1 = -1; prev = a_xclk;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50);
      if (a_xclk && !prev) begin
        if (t0 < 0) t0 = cyc;
        else if (t1 < 0) t1 = cyc;
      end
      prev = a_xclk;
    end
    check("xclk_period", 64'(t1 - t0), 64'd4);

    // Frame 1: clean frame
    vs_pulse();
    for (int r = 0; r < 4; r++) send_line(r, 8, -1);
    vs_pulse();
    check("f1_lat", 64'(lat_a), 64'd3);
    check("f1_a_cnt", 64'(qa.size()), 64'd32);
    check("f1_b_cnt", 64'(qb.size()), 64'd8);
    check("f1_c_cnt", 64'(qc.size()), 64'd32);
    for (int k = 0; k < qa.size(); k++) check("f1_a_pix", 64'(qa[k]), 64'(exp_a(k, 1'b0)));
    for (int k = 0; k < qb.size(); k++) check("f1_b_pix", 64'(qb[k]), 64'(exp_b(k)));
    for (int k = 0; k < qc.size(); k++) check("f1_c_pix", 64'(qc[k]), 64'(exp_a(k, 1'b1)));
    check("f1_a_first", 64'(qa[0]), 64'({10'd0, 10'd0, 19'd0, 8'd10}));
    check("f1_a_last", 64'(qa[31]), 64'({10'd7, 10'd3, 19'd31, 8'hFF}));
    check("f1_b_first", 64'(qb[0].v), 64'd11);
    check("f1_b_second", 64'(qb[1].v), 64'd200);
    check("f1_b_last_mem", 64'(qb[7].m), 64'd7);
    check("f1_c_corner", 64'(qc[0].v), 64'hFF);
    check("f1_c_interior", 64'(qc[17].v), 64'd15);
    check("f1_c_edge_col", 64'(qc[23].v), 64'hFF);
    check("f1_done", 64'({fd_a, fd_b, fd_c}), 64'({32'd1, 32'd1, 32'd1}));
    check("f1_fcnt", 64'({a_fcnt, b_fcnt, c_fcnt}), 64'({16'd1, 16'd1, 16'd1}));
    check("f1_err", 64'({a_err, b_err, c_err}), 64'd0);
    check("f1_start", 64'(fs_a), 64'd1);

    // Frame 2: first line carries 10 Y samples
    qa.delete(); qb.delete(); qc.delete();
    send_line(0, 10, -1);
    for (int r = 1; r < 4; r++) send_line(r, 8, -1);
    vs_pulse();
    check("f2_a_cnt", 64'(qa.size()), 64'd32);
    for (int k = 0; k < qa.size(); k++) check("f2_a_pix", 64'(qa[k]), 64'(exp_a(k, 1'b0)));
    check("f2_b_cnt", 64'(qb.size()), 64'd8);
    check("f2_err", 64'({a_err, b_err, c_err}), 64'b111);
    check("f2_fcnt", 64'(a_fcnt), 64'd2);

    // Frame 3: reset in the middle of line 2
    qa.delete(); qb.delete(); qc.delete();
    send_line(0, 8, -1);
    send_line(1, 8, -1);
    cam_byte(8'h80, 1'b1);
    cam_byte(yv(2, 0), 1'b1);
    reset = 1'b1;
    @(negedge clk_50);
    check("mid_rst_outs", 64'({a_val, a_err, a_fcnt, a_x, a_y}), 64'd0);
    check("mid_rst_pwr", 64'({a_pwdn, a_rst_n, a_xclk}), 64'b100);
    check("mid_rst_mem", 64'({a_mem, a_value}), 64'd0);
    repeat (2) @(negedge clk_50);
    reset = 1'b0;
    qa.delete(); qb.delete(); qc.delete();
    for (int i = 0; i < 300; i++) cam_byte(8'h40, 1'((i % 24) < 16));
    check("post_rst_rst_n", 64'(a_rst_n), 64'd1);
    check("post_rst_no_val", 64'(qa.size() + qb.size() + qc.size()), 64'd0);

    // Frame 4: vsync arrives mid-way through line 1
    vs_pulse();
    send_line(0, 8, -1);
    send_line(1, 8, 3);
    check("f4_a_cnt", 64'(qa.size()), 64'd11);
    for (int k = 0; k < qa.size(); k++) check("f4_a_pix", 64'(qa[k]), 64'(exp_a(k, 1'b0)));
    check("f4_b_cnt", 64'(qb.size()), 64'd4);
    check("f4_done", 64'({fd_a, fd_b, fd_c}), 64'({32'd3, 32'd3, 32'd3}));
    check("f4_fcnt", 64'({a_fcnt, b_fcnt, c_fcnt}), 64'({16'd1, 16'd1, 16'd1}));
    check("f4_err", 64'({a_err, b_err, c_err}), 64'b111);
    check("f4_start", 64'({fs_a, fs_b, fs_c}), 64'({32'd4, 32'd4, 32'd4}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
